// File: rtl/nat_conn_arbiter.sv
// Round-robin arbiter sharing one connection-table lookup engine among NUM_REQ parsers,
// with a per-lookup timeout that answers with an error instead of hanging the requester.
module nat_conn_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TUPLE_W = 128,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ*TUPLE_W-1:0] req_tuple_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [DATA_W-1:0]          resp_data_o,
  output logic                       resp_err_o,
  output logic [NUM_REQ-1:0]         resp_valid_o,
  output logic [TUPLE_W-1:0]         eng_tuple_o,
  output logic                       eng_valid_o,
  input  logic [DATA_W-1:0]          eng_data_i,
  input  logic                       eng_valid_i,
  output logic                       busy_o,
  output logic [GRANT_W-1:0]         grant_o,
  output logic [15:0]                stat_timeouts_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_e;

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GRANT_W-1:0] PTR_RST  = GRANT_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 eng_valid_q, eng_valid_d;
  logic [TUPLE_W-1:0]   eng_tuple_q, eng_tuple_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]    resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;
  logic                 busy_q, busy_d;
  logic [15:0]          stat_q, stat_d;

  logic                 arb_found;
  logic [GRANT_W-1:0]   arb_idx;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0]   grant_onehot;
  int                   arb_off;

  // Rotate the request vector so bit 0 is the requester just after the pointer;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    req_dbl   = {req_valid_i, req_valid_i};
    req_rot   = req_dbl >> (int'(grant_q) + 1);
    arb_found = |req_valid_i;
    arb_off   = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        arb_off = j;
      end
    end
    arb_idx = GRANT_W'((int'(grant_q) + 1 + arb_off) % NUM_REQ);
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = (GRANT_W'(i) == grant_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    eng_valid_d  = eng_valid_q;
    eng_tuple_d  = eng_tuple_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    stat_d       = stat_q;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d     = arb_idx;
          eng_tuple_d = req_tuple_i[int'(arb_idx)*TUPLE_W +: TUPLE_W];
          eng_valid_d = 1'b1;
          timer_d     = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result arriving on the final timer cycle still counts as a normal answer.
        if (eng_valid_i) begin
          resp_data_d  = eng_data_i;
          resp_err_d   = 1'b0;
          eng_valid_d  = 1'b0;
          resp_valid_d = grant_onehot;
          state_d      = S_RESP;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          eng_valid_d  = 1'b0;
          resp_valid_d = grant_onehot;
          stat_d       = (stat_q == 16'hFFFF) ? stat_q : stat_q + 16'd1;
          state_d      = S_RESP;
        end
      end
      S_RESP:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= PTR_RST;
      timer_q      <= '0;
      eng_valid_q  <= 1'b0;
      eng_tuple_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      stat_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      timer_q      <= timer_d;
      eng_valid_q  <= eng_valid_d;
      eng_tuple_q  <= eng_tuple_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      stat_q       <= stat_d;
    end
  end

  assign resp_data_o     = resp_data_q;
  assign resp_err_o      = resp_err_q;
  assign resp_valid_o    = resp_valid_q;
  assign eng_tuple_o     = eng_tuple_q;
  assign eng_valid_o     = eng_valid_q;
  assign busy_o          = busy_q;
  assign grant_o         = grant_q;
  assign stat_timeouts_o = stat_q;

endmodule

// File: tb/tb_nat_conn_arbiter.sv
// Randomized bench for nat_conn_arbiter: requesters and engine are behavioural,
// and every lookup is scored against a transaction-level round-robin/timeout model.
module tb_nat_conn_arbiter;
  localparam int NR  = 2;
  localparam int TW  = 128;
  localparam int DW  = 16;
  localparam int TMO = 4;
  localparam int GW  = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*TW-1:0] req_tuple_i;
  logic [NR-1:0]    req_valid_i;
  logic [DW-1:0]    resp_data_o;
  logic             resp_err_o;
  logic [NR-1:0]    resp_valid_o;
  logic [TW-1:0]    eng_tuple_o;
  logic             eng_valid_o;
  logic [DW-1:0]    eng_data_i;
  logic             eng_valid_i;
  logic             busy_o;
  logic [GW-1:0]    grant_o;
  logic [15:0]      stat_timeouts_o;

  nat_conn_arbiter #(.NUM_REQ(NR), .TUPLE_W(TW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_tuple_i(req_tuple_i), .req_valid_i(req_valid_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .resp_valid_o(resp_valid_o),
    .eng_tuple_o(eng_tuple_o), .eng_valid_o(eng_valid_o),
    .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i),
    .busy_o(busy_o), .grant_o(grant_o), .stat_timeouts_o(stat_timeouts_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester / engine / model state
  logic [NR-1:0] pend, prev_req, just_done;
  logic [TW-1:0] tup [NR];
  logic [DW-1:0] eng_val, force_data, exp_data;
  logic          force_data_en, exp_err, ev_prev;
  logic [15:0]   exp_stat;
  int            last_g, hi_cnt, eng_k, since_fall, req_pct, spur_pct, force_k, n_resp;
  int            gseq[$];

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int d = 1; d <= NR; d++) begin
      int c;
      c = (last + d) % NR;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    req_valid_i = pend;
    for (int i = 0; i < NR; i++) req_tuple_i[i*TW +: TW] = tup[i];
    prev_req = pend;
  endtask

  task automatic step();
    int  sf_prev, served, eg;
    logic exp_busy;
    @(negedge clk);
    just_done = '0;
    sf_prev   = since_fall;

    if (ev_prev)           exp_busy = 1'b1;
    else if (sf_prev == 0) exp_busy = 1'b1;
    else if (sf_prev == 1) exp_busy = 1'b0;
    else                   exp_busy = (prev_req != 0);
    chk("busy", busy_o, exp_busy);

    // From IDLE a lookup must start exactly when some request was visible.
    if (!ev_prev) chk("start", eng_valid_o, (sf_prev >= 2) && (prev_req != 0));

    if (eng_valid_o && !ev_prev && prev_req != 0) begin
      eg = rr_pick(prev_req, last_g);
      chk("grant", grant_o, eg);
      chk("eng_tuple", eng_tuple_o, tup[eg]);
      last_g  = eg;
      hi_cnt  = 0;
      eng_k   = (force_k > 0) ? force_k : $urandom_range(1, 6);
      eng_val = force_data_en ? force_data : DW'($urandom);
    end

    if (!eng_valid_o && ev_prev) begin
      served = (eng_k <= TMO) ? eng_k : TMO;
      chk("eng_hold", hi_cnt, served);
      if (eng_k > TMO) begin
        if (exp_stat != 16'hFFFF) exp_stat++;
        exp_data = '0;
        exp_err  = 1'b1;
      end else begin
        exp_data = eng_val;
        exp_err  = 1'b0;
      end
      chk("resp_vld", resp_valid_o, 1 << last_g);
      chk("resp_data", resp_data_o, exp_data);
      chk("resp_err", resp_err_o, exp_err);
      chk("stat", stat_timeouts_o, exp_stat);
      pend[last_g]      = 1'b0;
      just_done[last_g] = 1'b1;
      gseq.push_back(last_g);
      n_resp++;
      since_fall = 0;
    end else begin
      chk("no_resp", resp_valid_o, 0);
      chk("data_hold", resp_data_o, exp_data);
      chk("err_hold", resp_err_o, exp_err);
      if (since_fall < 1000) since_fall++;
    end

    if (eng_valid_o) hi_cnt++;

    if (eng_valid_o && hi_cnt == eng_k) begin
      eng_valid_i = 1'b1;
      eng_data_i  = eng_val;
    end else if (!eng_valid_o && $urandom_range(0, 99) < spur_pct) begin
      eng_valid_i = 1'b1;
      eng_data_i  = DW'($urandom);
    end else begin
      eng_valid_i = 1'b0;
      eng_data_i  = DW'($urandom);
    end

    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && !just_done[i] && $urandom_range(0, 99) < req_pct) begin
        pend[i] = 1'b1;
        tup[i]  = {24'h0, $urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom)};
      end
    end
    drive_reqs();
    ev_prev = eng_valid_o;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    pend        = '0;
    eng_valid_i = 1'b0;
    drive_reqs();
    @(negedge clk);
    reset = 1'b1;
    chk("rst_eng_vld", eng_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_resp_vld", resp_valid_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_resp_err", resp_err_o, 0);
    chk("rst_stat", stat_timeouts_o, 0);
    chk("rst_grant", grant_o, NR - 1);
    chk("rst_tuple", eng_tuple_o, 0);
    last_g     = NR - 1;
    exp_stat   = '0;
    exp_data   = '0;
    exp_err    = 1'b0;
    ev_prev    = 1'b0;
    since_fall = 2;
    hi_cnt     = 0;
  endtask

  task automatic run_lookups(input int n, input int maxc);
    int tgt, c;
    tgt = n_resp + n;
    c   = 0;
    while (n_resp < tgt && c < maxc) begin
      step();
      c++;
    end
    chk("lookup_bound", n_resp >= tgt, 1);
  endtask

  initial begin
    int s, c;
    logic [TW-1:0] t0;
    pend = '0; prev_req = '0; just_done = '0;
    for (int i = 0; i < NR; i++) tup[i] = '0;
    req_tuple_i = '0; eng_data_i = '0;
    req_pct = 0; spur_pct = 0; force_k = 0; force_data_en = 1'b0; force_data = '0;
    n_resp = 0; eng_k = 1; eng_val = '0;
    do_reset();

    // Single request with a known tuple, engine answers on the 4th valid cycle.
    t0 = 128'h0A00_0001_0A00_0002_1234_0050_06;
    force_k = 4; force_data_en = 1'b1; force_data = 16'h0025;
    pend = 2'b01; tup[0] = t0;
    step();
    step();
    chk("lat1_eng_vld", eng_valid_o, 1);
    chk("lat1_tuple", eng_tuple_o, t0);
    run_lookups(1, 20);
    chk("single_data", resp_data_o, 16'h0025);
    for (int i = 0; i < 3; i++) step();

    // Spurious engine strobes while idle must be ignored.
    spur_pct = 100;
    for (int i = 0; i < 5; i++) step();
    spur_pct = 0;

    // Contention with a 1-cycle engine: grants alternate starting at 0.
    do_reset();
    force_k = 1; force_data_en = 1'b0; req_pct = 100;
    pend = 2'b11;
    s = gseq.size();
    run_lookups(6, 60);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), gseq[s + i], i % 2);

    // Timeouts and the race on the final timer cycle.
    do_reset();
    req_pct = 0; force_k = 7;
    pend = 2'b01;
    run_lookups(1, 20);
    chk("tmo1_stat", stat_timeouts_o, 1);
    chk("tmo1_err", resp_err_o, 1);
    pend = 2'b10;
    run_lookups(1, 20);
    chk("tmo2_stat", stat_timeouts_o, 2);
    force_k = TMO;
    pend = 2'b01;
    run_lookups(1, 20);
    chk("race_err", resp_err_o, 0);
    chk("race_stat", stat_timeouts_o, 2);
    for (int i = 0; i < 3; i++) step();

    // Reset in the middle of a lookup, then a late engine strobe.
    force_k = 7;
    pend = 2'b11;
    c = 0;
    while (!eng_valid_o && c < 10) begin
      step();
      c++;
    end
    chk("mid_wait_reached", eng_valid_o, 1);
    step();
    do_reset();
    spur_pct = 100;
    for (int i = 0; i < 4; i++) step();
    spur_pct = 0;
    force_k = 2;
    pend = 2'b11;
    s = gseq.size();
    run_lookups(1, 20);
    chk("post_rst_first", gseq[s], 0);

    // Randomized traffic with mixed latencies, timeouts and spurious strobes.
    force_k = 0; req_pct = 30; spur_pct = 20;
    for (int i = 0; i < 2000; i++) step();
    req_pct = 0; spur_pct = 0;
    for (int i = 0; i < 40; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
